// File: rtl/seq_div_pkg.sv
// Shared definitions for the 8-bit sequential restoring divider.
// Holds the controller state type, the operand width, the number of
// restoring iterations and the iteration counter width/terminal value.
package seq_div_pkg;

    localparam int WIDTH = 8;
    localparam int ITER  = 8;
    localparam int CNT_W = 3;

    // Counter value seen during the last restoring step.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
// Ports:
//   rem_shift_i : (WIDTH+1)-bit partial remainder, already shifted left with
//                 the next dividend bit in its LSB
//   divisor_i   : WIDTH-bit unsigned divisor
//   rem_next_o  : WIDTH-bit partial remainder after the trial subtraction
//   q_bit_o     : quotient bit produced by this step
module div_step
    import seq_div_pkg::*;
(
    input  logic [WIDTH:0]   rem_shift_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_next_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] divisor_ext;
    logic [WIDTH:0] diff;

    // Compare directly rather than relying on the sign bit of the
    // difference: the shifted remainder may use all 9 bits. Whichever value
    // is kept always fits in WIDTH bits, because the kept remainder is
    // strictly smaller than the divisor.
    always_comb begin
        divisor_ext = {1'b0, divisor_i};
        diff        = rem_shift_i - divisor_ext;
        q_bit_o     = 1'b0;
        rem_next_o  = rem_shift_i[WIDTH-1:0];
        if (rem_shift_i >= divisor_ext) begin
            q_bit_o    = 1'b1;
            rem_next_o = diff[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/seq_divider_8bit.sv
// 8-bit unsigned sequential divider (restoring, one bit per clock).
// Ports:
//   clk_i         : clock, all state updates on the rising edge
//   rst_i         : synchronous active-high reset
//   start_i       : start request, accepted only while ready_o is high
//   dividend_i    : unsigned dividend, sampled with start_i
//   divisor_i     : unsigned divisor, sampled with start_i
//   ready_o       : high while idle
//   valid_o       : one-cycle pulse when the result outputs are fresh
//   quotient_o    : quotient (all ones on divide by zero)
//   remainder_o   : remainder (the dividend on divide by zero)
//   div_by_zero_o : the last accepted divisor was zero
// Results are held in dedicated output registers so they stay stable while
// the next division is being computed.
module seq_divider_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    import seq_div_pkg::*;

    state_e             state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [WIDTH-1:0]   rem_q,     rem_d;
    logic [WIDTH-1:0]   quo_q,     quo_d;
    logic [WIDTH-1:0]   dvd_q,     dvd_d;
    logic [WIDTH-1:0]   dsr_q,     dsr_d;
    logic [WIDTH-1:0]   quo_out_q, quo_out_d;
    logic [WIDTH-1:0]   rem_out_q, rem_out_d;
    logic               dbz_q,     dbz_d;

    logic [WIDTH-1:0]   step_rem;
    logic               step_qbit;
    logic [WIDTH-1:0]   step_quo;

    div_step u_div_step (
        .rem_shift_i (({rem_q, dvd_q[WIDTH-1]})),
        .divisor_i   (dsr_q),
        .rem_next_o  (step_rem),
        .q_bit_o     (step_qbit)
    );

    assign step_quo = {quo_q[WIDTH-2:0], step_qbit};

    // Next-state logic. The working registers (rem/quo/dvd) advance during
    // CALC; the visible result registers change only on entry to DONE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        quo_out_d = quo_out_q;
        rem_out_d = rem_out_q;
        dbz_d     = dbz_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (divisor_i == '0) begin
                        state_d   = DONE;
                        quo_out_d = '1;
                        rem_out_d = dividend_i;
                        dbz_d     = 1'b1;
                    end else begin
                        state_d = CALC;
                        dvd_d   = dividend_i;
                        dsr_d   = divisor_i;
                        rem_d   = '0;
                        quo_d   = '0;
                        cnt_d   = '0;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d   = DONE;
                    quo_out_d = step_quo;
                    rem_out_d = step_rem;
                    dbz_d     = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            quo_out_q <= '0;
            rem_out_q <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvd_q     <= dvd_d;
            dsr_q     <= dsr_d;
            quo_out_q <= quo_out_d;
            rem_out_q <= rem_out_d;
            dbz_q     <= dbz_d;
        end
    end

    assign ready_o       = (state_q == IDLE);
    assign valid_o       = (state_q == DONE);
    assign quotient_o    = quo_out_q;
    assign remainder_o   = rem_out_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_seq_divider_8bit.sv
// Scoreboard bench for seq_divider_8bit: the driver pushes the expected
// result and the cycle it must appear in; a monitor pops on every valid_o.
module tb_seq_divider_8bit;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       ready;
    logic       valid;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    typedef struct {
        logic [7:0] quo;
        logic [7:0] rem;
        logic       dbz;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   misses  = 0;
    int   cycle_cnt = 0;

    seq_divider_8bit #(.WIDTH(8)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .dividend_i    (dividend),
        .divisor_i     (divisor),
        .ready_o       (ready),
        .valid_o       (valid),
        .quotient_o    (quotient),
        .remainder_o   (remainder),
        .div_by_zero_o (div_by_zero)
    );

    // 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle counter used to time result latency.
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            misses++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, actual, expected, cycle_cnt);
        end
    endtask

    // Called at a falling edge; waits (bounded) for the divider to be idle.
    task automatic waitReady();
        int n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready) checkOutput("readyTimeout", 32'(ready), 32'd1);
    endtask

    // Drives one start pulse and, if a result is expected, queues it with
    // the cycle in which valid_o must appear. Returns at the falling edge of
    // the first cycle after the accepting edge.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input bit expect_result, input logic [7:0] eq,
                                 input logic [7:0] er, input logic edbz);
        exp_t e;
        waitReady();
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        if (expect_result) begin
            e.quo = eq;
            e.rem = er;
            e.dbz = edbz;
            e.cyc = cycle_cnt + ((b == 8'd0) ? 0 : 8);
            sb.push_back(e);
        end
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
        @(negedge clk);
    endtask

    task automatic waitDrain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) checkOutput("drainTimeout", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: every valid_o pulse must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpectedValid", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("latency",   32'(cycle_cnt), 32'(e.cyc));
                    checkOutput("quotient",  32'(quotient),  32'(e.quo));
                    checkOutput("remainder", 32'(remainder), 32'(e.rem));
                    checkOutput("divByZero", 32'(div_by_zero), 32'(e.dbz));
                end
            end
        end
    end

    // Directed sequence followed by a random sweep against a / and % model.
    initial begin
        logic [7:0] a;
        logic [7:0] b;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("resetReady",     32'(ready),       32'd1);
        checkOutput("resetValid",     32'(valid),       32'd0);
        checkOutput("resetQuotient",  32'(quotient),    32'd0);
        checkOutput("resetRemainder", 32'(remainder),   32'd0);
        checkOutput("resetDivByZero", 32'(div_by_zero), 32'd0);

        // Started on the very first edge after reset release.
        applyStimulus(8'd100, 8'd7,   1'b1, 8'd14,  8'd2,  1'b0);
        applyStimulus(8'd255, 8'd1,   1'b1, 8'd255, 8'd0,  1'b0);
        applyStimulus(8'd5,   8'd10,  1'b1, 8'd0,   8'd5,  1'b0);
        applyStimulus(8'd200, 8'd200, 1'b1, 8'd1,   8'd0,  1'b0);
        applyStimulus(8'd42,  8'd0,   1'b1, 8'hFF,  8'd42, 1'b1);
        waitDrain();

        // A second start during CALC must be ignored.
        applyStimulus(8'd100, 8'd7, 1'b1, 8'd14, 8'd2, 1'b0);
        repeat (2) @(negedge clk);
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 8'd3;
        @(negedge clk);
        start = 1'b0;
        waitDrain();
        @(negedge clk);
        checkOutput("readyAfterIgnored", 32'(ready), 32'd1);

        // Previous result must hold while the next division is computing.
        applyStimulus(8'd5, 8'd10, 1'b1, 8'd0, 8'd5, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("holdQuotient",  32'(quotient),    32'd14);
        checkOutput("holdRemainder", 32'(remainder),   32'd2);
        checkOutput("holdDivByZero", 32'(div_by_zero), 32'd0);
        waitDrain();

        // Reset in CALC cycle 4 aborts 100/7 without a result.
        applyStimulus(8'd100, 8'd7, 1'b0, 8'd0, 8'd0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abortReady",     32'(ready),       32'd1);
        checkOutput("abortValid",     32'(valid),       32'd0);
        checkOutput("abortQuotient",  32'(quotient),    32'd0);
        checkOutput("abortRemainder", 32'(remainder),   32'd0);
        checkOutput("abortDivByZero", 32'(div_by_zero), 32'd0);
        repeat (12) @(negedge clk);
        applyStimulus(8'd50, 8'd6, 1'b1, 8'd8, 8'd2, 1'b0);
        waitDrain();

        // Random sweep checked against the reference model.
        for (int i = 0; i < 3000; i++) begin
            a = 8'($urandom_range(0, 255));
            b = (i % 97 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            if (b == 8'd0)
                applyStimulus(a, b, 1'b1, 8'hFF, a, 1'b1);
            else
                applyStimulus(a, b, 1'b1, a / b, a % b, 1'b0);
        end
        waitDrain();
        repeat (2) @(negedge clk);
        checkOutput("pendingResults", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
